// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: PC-1 on load, one C/D rotation per round, PC-2 out.
// Optional key parity flag built only when DES_KEY_SCHED_PARITY_CHECK_EN is defined.
module des_key_schedule (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [63:0] i_key,
  input  logic        i_decrypt,
  input  logic        i_advance,
  output logic [47:0] o_subkey,
  output logic [3:0]  o_round,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_parity_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  // Tables hold DES bit numbers; DES bit 1 is the MSB of the source vector.
  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  logic [0:0]  state_reg;
  logic [27:0] c_reg, d_reg;
  logic [3:0]  round_reg;
  logic        dec_reg;
  logic        done_reg;
  logic [55:0] pc1_cd;
  logic [55:0] cd;
  logic [47:0] pc2_key;
  logic [4:0]  key_num;
  logic        shift_one;
  logic        start_ok;

  assign cd       = {c_reg, d_reg};
  assign start_ok = (state_reg == IDLE) && i_start;

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      assign pc1_cd[55-gi] = i_key[64-PC1_TAB[gi]];
    end
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      assign pc2_key[47-gi] = cd[56-PC2_TAB[gi]];
    end
  endgenerate

  // Encrypt steps toward the next key number; decrypt undoes the current one's shift.
  assign key_num   = dec_reg ? (5'd16 - {1'b0, round_reg}) : ({1'b0, round_reg} + 5'd2);
  assign shift_one = (key_num == 5'd1) || (key_num == 5'd2) ||
                     (key_num == 5'd9) || (key_num == 5'd16);

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
    return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
    return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      c_reg     <= '0;
      d_reg     <= '0;
      round_reg <= '0;
      dec_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            state_reg <= ACTIVE;
            round_reg <= '0;
            dec_reg   <= i_decrypt;
            if (i_decrypt) begin
              c_reg <= pc1_cd[55:28];
              d_reg <= pc1_cd[27:0];
            end else begin
              c_reg <= rotl(pc1_cd[55:28], 1'b1);
              d_reg <= rotl(pc1_cd[27:0], 1'b1);
            end
          end
        end
        default: begin
          if (i_advance) begin
            if (round_reg == 4'd15) begin
              state_reg <= IDLE;
              round_reg <= '0;
              done_reg  <= 1'b1;
            end else begin
              round_reg <= round_reg + 4'd1;
              if (dec_reg) begin
                c_reg <= rotr(c_reg, shift_one);
                d_reg <= rotr(d_reg, shift_one);
              end else begin
                c_reg <= rotl(c_reg, shift_one);
                d_reg <= rotl(d_reg, shift_one);
              end
            end
          end
        end
      endcase
    end
  end

  assign o_valid  = (state_reg == ACTIVE);
  assign o_busy   = (state_reg == ACTIVE);
  assign o_round  = round_reg;
  assign o_done   = done_reg;
  assign o_subkey = o_valid ? pc2_key : 48'h0;

`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
  logic [7:0] byte_even;
  logic       parity_reg;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_par
      assign byte_even[gi] = ~^i_key[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      parity_reg <= 1'b0;
    else if (start_ok)
      parity_reg <= |byte_even;
  end

  assign o_parity_err = parity_reg;
`else
  // Parity bits and the accept strobe have no consumer in this build.
  logic unused_parity;
  assign unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                           i_key[24], i_key[16], i_key[8], i_key[0], start_ok};
  assign o_parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized self-checking bench for des_key_schedule against a cumulative-shift DES key model.
// Honours DES_KEY_SCHED_PARITY_CHECK_EN for the parity-flag checks.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] key;
  logic        decrypt;
  logic        advance;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        valid;
  logic        busy;
  logic        done;
  logic        parity_err;

  int n_checks = 0;
  int n_pass   = 0;
  logic [47:0] enc_cap [16];
  logic [47:0] dec_cap [16];

  des_key_schedule dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_key        (key),
    .i_decrypt    (decrypt),
    .i_advance    (advance),
    .o_subkey     (subkey),
    .o_round      (round),
    .o_valid      (valid),
    .o_busy       (busy),
    .o_done       (done),
    .o_parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Key number kn (1..16) = PC-2 of C0/D0 rotated left by the cumulative shift total.
  function automatic logic [47:0] model_key(input logic [63:0] k, input int kn);
    bit c0 [28];
    bit d0 [28];
    bit cd [56];
    int total;
    logic [47:0] r;
    for (int i = 0; i < 28; i++) begin
      c0[i] = k[64 - pc1_t[i]];
      d0[i] = k[64 - pc1_t[28 + i]];
    end
    total = 0;
    for (int i = 0; i < kn; i++) total += shifts[i];
    for (int i = 0; i < 28; i++) begin
      cd[i]      = c0[(i + total) % 28];
      cd[28 + i] = d0[(i + total) % 28];
    end
    for (int i = 0; i < 48; i++) r[47 - i] = cd[pc2_t[i] - 1];
    return r;
  endfunction

  function automatic logic model_parity(input logic [63:0] k);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 8; b++)
      if ($countones(k[8*b +: 8]) % 2 == 0) e = 1'b1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, {63'h0, valid}, 64'h0);
    check({tag, "_busy"}, {63'h0, busy}, 64'h0);
    check({tag, "_round"}, {60'h0, round}, 64'h0);
    check({tag, "_subkey"}, {16'h0, subkey}, 64'h0);
  endtask

  // One full sequence; max_stall>0 inserts random stalls with noise on start/key/decrypt.
  task automatic run_seq(input logic [63:0] k, input logic dec, input int max_stall,
                         input logic adv_with_start, output logic [47:0] cap [16]);
    int kn;
    logic [47:0] exp;
    start = 1'b1; key = k; decrypt = dec; advance = adv_with_start;
    tick();
    start = 1'b0; advance = 1'b0;
    for (int pos = 0; pos < 16; pos++) begin
      kn  = dec ? 16 - pos : pos + 1;
      exp = model_key(k, kn);
      check("seq_valid", {63'h0, valid}, 64'h1);
      check("seq_busy", {63'h0, busy}, 64'h1);
      check("seq_round", {60'h0, round}, 64'(pos));
      check("seq_subkey", {16'h0, subkey}, {16'h0, exp});
      cap[pos] = subkey;
      if (max_stall > 0) begin
        int ns;
        ns = $urandom_range(max_stall, 0);
        for (int s = 0; s < ns; s++) begin
          start = 1'($urandom); key = {$urandom, $urandom}; decrypt = 1'($urandom);
          tick();
          check("stall_subkey", {16'h0, subkey}, {16'h0, exp});
          check("stall_round", {60'h0, round}, 64'(pos));
        end
        start = 1'b0;
      end
      advance = 1'b1;
      tick();
      advance = 1'b0;
    end
    check("end_done", {63'h0, done}, 64'h1);
    check_idle("end");
    $display("seq key=%h dec=%0d stall=%0d complete", k, dec, max_stall);
  endtask

  initial begin
    logic [63:0] rk;
    logic        rd;
    logic [47:0] scratch [16];
    logic [47:0] hold;

    rst_n = 1'b0; start = 1'b0; key = '0; decrypt = 1'b0; advance = 1'b0;
    repeat (2) tick();
    check_idle("reset");
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_parity", {63'h0, parity_err}, 64'h0);
    rst_n = 1'b1;
    tick();

    // Advance while idle does nothing.
    advance = 1'b1;
    tick();
    advance = 1'b0;
    check_idle("idle_adv");

    // Reference vector, encrypt then decrypt.
    run_seq(64'h133457799BBCDFF1, 1'b0, 0, 1'b0, enc_cap);
    check("k1_enc", {16'h0, enc_cap[0]}, 64'h1B02EFFC7072);
    check("k16_enc", {16'h0, enc_cap[15]}, 64'hCB3D8B0E17F5);
    tick();
    check("done_pulse", {63'h0, done}, 64'h0);
    check("parity_good", {63'h0, parity_err}, 64'h0);

    run_seq(64'h133457799BBCDFF1, 1'b1, 0, 1'b1, dec_cap);
    check("k16_dec_first", {16'h0, dec_cap[0]}, 64'hCB3D8B0E17F5);
    check("k1_dec_last", {16'h0, dec_cap[15]}, 64'h1B02EFFC7072);
    for (int i = 0; i < 16; i++)
      check("dec_reverse", {16'h0, dec_cap[i]}, {16'h0, enc_cap[15 - i]});

    // Restart in the same cycle as done.
    start = 1'b1; key = 64'h0E329232EA6D0D73; decrypt = 1'b0;
    tick();
    start = 1'b0;
    check("restart_valid", {63'h0, valid}, 64'h1);
    check("restart_key", {16'h0, subkey}, {16'h0, model_key(64'h0E329232EA6D0D73, 1)});

    // Stall at round 3 with start pulsed mid-sequence.
    advance = 1'b1;
    repeat (3) tick();
    advance = 1'b0;
    hold = model_key(64'h0E329232EA6D0D73, 4);
    for (int s = 0; s < 5; s++) begin
      start = (s == 2); key = 64'hFFFF0000FFFF0000; decrypt = 1'b1;
      tick();
      check("hold_round", {60'h0, round}, 64'd3);
      check("hold_subkey", {16'h0, subkey}, {16'h0, hold});
    end
    start = 1'b0;

    // Reset asynchronously at round 7.
    advance = 1'b1;
    repeat (4) tick();
    advance = 1'b0;
    check("pre_rst_round", {60'h0, round}, 64'd7);
    rst_n = 1'b0;
    #2;
    check_idle("mid_rst");
    check("mid_rst_done", {63'h0, done}, 64'h0);
    rst_n = 1'b1;
    tick();
    check_idle("post_rst");

    // Parity flag.
    start = 1'b1; key = 64'h123457799BBCDFF1; decrypt = 1'b0;
    tick();
    start = 1'b0;
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
    check("parity_bad", {63'h0, parity_err}, 64'h1);
`else
    check("parity_off", {63'h0, parity_err}, 64'h0);
`endif
    advance = 1'b1;
    for (int pos = 0; pos < 16; pos++) begin
      check("par_seq_key", {16'h0, subkey}, {16'h0, model_key(64'h123457799BBCDFF1, pos + 1)});
      tick();
    end
    advance = 1'b0;
    check("par_seq_done", {63'h0, done}, 64'h1);

    // Random keys, directions and stalls.
    for (int t = 0; t < 8; t++) begin
      rk = {$urandom, $urandom};
      rd = 1'($urandom);
      run_seq(rk, rd, (t % 2 == 0) ? 3 : 0, 1'($urandom), scratch);
`ifdef DES_KEY_SCHED_PARITY_CHECK_EN
      check("rand_parity", {63'h0, parity_err}, {63'h0, model_parity(rk)});
`else
      check("rand_parity", {63'h0, parity_err}, 64'h0);
`endif
      repeat ($urandom_range(2, 0)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
